// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift blocks: FSM state encoding and default word width.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : shift_pkg

// File: rtl/bit_counter.sv
// Bit position counter for the serializer; flags the final bit of a word.
module bit_counter
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     last
);

    localparam int CW = $clog2(WIDTH);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign last = (count == CW'(WIDTH - 1));

endmodule : bit_counter

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: one-word holding buffer feeding an LSB-first shifter,
// back-to-back words are sent with no gap cycles.
module piso_shift_tx
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] buf_data;
    logic             buf_full;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic [CW-1:0]    bit_idx;
    logic             last;
    logic             reload;
    logic             shift_en;
    logic             finish;
    logic             accept;

    assign load_ready = !buf_full;
    assign accept     = load_valid && !buf_full;
    assign busy       = (state == SHIFT) || buf_full;

    bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .clr  (!rst_n || reload || finish),
        .en   (shift_en),
        .count(count),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        reload    = 1'b0;
        shift_en  = 1'b0;
        finish    = 1'b0;
        bit_idx   = count + CW'(1);
        unique case (state)
            IDLE: begin
                if (buf_full) begin
                    reload    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!last) begin
                    shift_en = 1'b1;
                end else if (buf_full) begin
                    reload = 1'b1;
                end else begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The word is held in place and bits are picked by the counter, so the
    // counter position always equals the index of the bit currently on dout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_data    <= '0;
            buf_full    <= 1'b0;
            shreg       <= '0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (accept) begin
                buf_data <= load_data;
                buf_full <= 1'b1;
            end else if (reload) begin
                buf_full <= 1'b0;
            end
            if (reload) begin
                shreg       <= buf_data;
                dout        <= buf_data[0];
                dout_valid  <= 1'b1;
                frame_start <= 1'b1;
            end else if (shift_en) begin
                dout <= shreg[bit_idx];
            end else if (finish) begin
                dout       <= 1'b0;
                dout_valid <= 1'b0;
            end
        end
    end

endmodule : piso_shift_tx

// File: tb/tb_piso_shift_tx.sv
// Directed self-checking bench for piso_shift_tx at WIDTH=8 and WIDTH=16.
module tb_piso_shift_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  load_data;
    logic        load_valid;
    logic        load_ready;
    logic        dout;
    logic        dout_valid;
    logic        frame_start;
    logic        busy;

    logic [15:0] load16_data;
    logic        load16_valid;
    logic        load16_ready;
    logic        dout16;
    logic        dout16_valid;
    logic        frame16_start;
    logic        busy16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_start(frame_start),
        .busy       (busy)
    );

    piso_shift_tx #(.WIDTH(16)) u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_data  (load16_data),
        .load_valid (load16_valid),
        .load_ready (load16_ready),
        .dout       (dout16),
        .dout_valid (dout16_valid),
        .frame_start(frame16_start),
        .busy       (busy16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [0:7]  s_a5;
        bit [0:15] s_0ff0;
        bit [7:0]  w3c;
        bit        rdy_e;
        bit        vld_e;
        bit        fs_e;
        int        frames;

        s_a5   = 8'b1010_0101;
        s_0ff0 = 16'b1111_0000_0000_1111;
        w3c    = 8'h3C;

        rst_n        = 1'b0;
        load_data    = '0;
        load_valid   = 1'b0;
        load16_data  = '0;
        load16_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_dout",        {31'd0, dout},        32'd0);
        chk("rst_dout_valid",  {31'd0, dout_valid},  32'd0);
        chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
        chk("rst_busy",        {31'd0, busy},        32'd0);
        chk("rst_load_ready",  {31'd0, load_ready},  32'd1);
        chk("rst16_ready",     {31'd0, load16_ready}, 32'd1);
        chk("rst16_valid",     {31'd0, dout16_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single word A5
        load_data  = 8'hA5;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("a5_ready_after_accept", {31'd0, load_ready}, 32'd0);
        chk("a5_busy_after_accept",  {31'd0, busy},       32'd1);
        chk("a5_no_bit_yet",         {31'd0, dout_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("a5_dout_%0d", i),  {31'd0, dout},        {31'd0, s_a5[i]});
            chk($sformatf("a5_valid_%0d", i), {31'd0, dout_valid},  32'd1);
            chk($sformatf("a5_fs_%0d", i),    {31'd0, frame_start}, (i == 0) ? 32'd1 : 32'd0);
        end
        tick();
        chk("a5_end_valid", {31'd0, dout_valid}, 32'd0);
        chk("a5_end_dout",  {31'd0, dout},       32'd0);
        chk("a5_end_busy",  {31'd0, busy},       32'd0);
        chk("a5_end_ready", {31'd0, load_ready}, 32'd1);

        // Back-to-back 0F then F0
        load_data  = 8'h0F;
        load_valid = 1'b1;
        tick();
        chk("b2b_ready_full", {31'd0, load_ready}, 32'd0);
        load_data = 8'hF0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 1) load_valid = 1'b0;
            chk($sformatf("b2b_dout_%0d", i),  {31'd0, dout},        {31'd0, s_0ff0[i]});
            chk($sformatf("b2b_valid_%0d", i), {31'd0, dout_valid},  32'd1);
            chk($sformatf("b2b_fs_%0d", i),    {31'd0, frame_start}, (i == 0 || i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("b2b_ready_%0d", i), {31'd0, load_ready},  (i == 0 || i >= 8) ? 32'd1 : 32'd0);
        end
        tick();
        chk("b2b_end_valid", {31'd0, dout_valid}, 32'd0);

        // 3C held valid for 20 edges: accepts at edges 1, 3, 11, 19 only
        load_data  = 8'h3C;
        load_valid = 1'b1;
        frames     = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 20) load_valid = 1'b0;
            rdy_e = !(e == 1 || (e >= 3 && e <= 9) || (e >= 11 && e <= 17) || (e >= 19 && e <= 25));
            vld_e = (e >= 2 && e <= 33);
            fs_e  = (e == 2 || e == 10 || e == 18 || e == 26);
            if (frame_start) frames++;
            chk($sformatf("h3c_ready_%0d", e), {31'd0, load_ready},  {31'd0, rdy_e});
            chk($sformatf("h3c_valid_%0d", e), {31'd0, dout_valid},  {31'd0, vld_e});
            chk($sformatf("h3c_fs_%0d", e),    {31'd0, frame_start}, {31'd0, fs_e});
            chk($sformatf("h3c_dout_%0d", e),  {31'd0, dout},        vld_e ? {31'd0, w3c[(e - 2) % 8]} : 32'd0);
        end
        chk("h3c_frame_count", frames, 32'd4);

        // FF in flight, 55 buffered, reset during bit 3
        load_data  = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_data = 8'h55;
        tick();
        chk("rmf_bit0_fs", {31'd0, frame_start}, 32'd1);
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        chk("rmf_bit3_dout",  {31'd0, dout},       32'd1);
        chk("rmf_bit3_ready", {31'd0, load_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rmf_valid", {31'd0, dout_valid},  32'd0);
        chk("rmf_dout",  {31'd0, dout},        32'd0);
        chk("rmf_ready", {31'd0, load_ready},  32'd1);
        chk("rmf_busy",  {31'd0, busy},        32'd0);
        chk("rmf_fs",    {31'd0, frame_start}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("rmf_quiet_%0d", i), {31'd0, dout_valid}, 32'd0);
        end

        // Reset wins over a simultaneous handshake
        rst_n      = 1'b0;
        load_data  = 8'h33;
        load_valid = 1'b1;
        tick();
        rst_n      = 1'b0;
        load_valid = 1'b0;
        chk("rpri_ready", {31'd0, load_ready}, 32'd1);
        chk("rpri_busy",  {31'd0, busy},       32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rpri_valid", {31'd0, dout_valid}, 32'd0);
        chk("rpri_busy2", {31'd0, busy},       32'd0);

        // WIDTH=16, word 8001
        load16_data  = 16'h8001;
        load16_valid = 1'b1;
        tick();
        load16_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("w16_dout_%0d", i),  {31'd0, dout16},        (i == 0 || i == 15) ? 32'd1 : 32'd0);
            chk($sformatf("w16_valid_%0d", i), {31'd0, dout16_valid},  32'd1);
            chk($sformatf("w16_fs_%0d", i),    {31'd0, frame16_start}, (i == 0) ? 32'd1 : 32'd0);
        end
        tick();
        chk("w16_end_valid", {31'd0, dout16_valid}, 32'd0);
        chk("w16_end_busy",  {31'd0, busy16},       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_piso_shift_tx

// File: doc/piso_shift_tx.md
PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: serial word length in bits; legal range WIDTH >= 2.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port load_data, input, WIDTH: parallel word to serialize.
REQ-005 SHALL have port load_valid, input, 1: load_data valid this cycle.
REQ-006 SHALL have port load_ready, output, 1: block can accept a word this cycle.
REQ-007 SHALL have port dout, output, 1: serial data, LSB first.
REQ-008 SHALL have port dout_valid, output, 1: dout carries a valid bit this cycle.
REQ-009 SHALL have port frame_start, output, 1: one-cycle pulse coincident with bit 0 of each word.
REQ-010 SHALL have port busy, output, 1: high whenever the shifter or the holding buffer contains data.

Function
REQ-011 SHALL contain a one-word holding buffer (buf_data, buf_full) and a WIDTH-bit shift register with a bit counter of $clog2(WIDTH) bits.
REQ-012 SHALL drive load_ready = !buf_full, decoded from registers only, with no combinational path from load_valid.
REQ-013 SHALL accept a word on an edge where load_valid && load_ready; buf_data <= load_data, buf_full <= 1.
REQ-014 SHALL implement two states, IDLE and SHIFT.
REQ-015 IDLE with buf_full=1 at an edge: SHALL move the buffer into the shifter, clear buf_full, drive dout <= buf_data[0], dout_valid <= 1, frame_start <= 1, count <= 0, and enter SHIFT.
REQ-016 In SHIFT with count < WIDTH-1: SHALL on each edge drive the next bit to dout, increment count, and hold frame_start at 0.
REQ-017 In SHIFT with count == WIDTH-1 and buf_full=1: SHALL reload per REQ-015 on that same edge, giving zero gap cycles between words.
REQ-018 In SHIFT with count == WIDTH-1 and buf_full=0: SHALL drive dout_valid <= 0 and dout <= 0, and return to IDLE.
REQ-019 Latency: SHALL present bit 0 of a word accepted at edge k, with the shifter idle, on dout during the cycle after edge k+1; bit i SHALL follow at edge k+1+i.
REQ-020 SHALL hold dout at 0 whenever dout_valid is 0.
REQ-021 Buffer freed on a reload edge: SHALL raise load_ready from the next cycle, allowing a refill within WIDTH-1 cycles and sustained 100% line utilization.
REQ-022 load_valid held while load_ready=0: SHALL ignore the word; each word is taken exactly once.

Reset
REQ-023 rst_n=0 at an edge: SHALL set state IDLE, buf_full 0, count 0, shifter 0, dout 0, dout_valid 0, frame_start 0; busy=0 and load_ready=1 follow.
REQ-024 Reset mid-frame: SHALL discard both the partial word and the buffered word, with no further valid bits emitted.
REQ-025 rst_n=0: SHALL take priority over a simultaneous load handshake.

Structure
REQ-026 Package shift_pkg SHALL hold the state encoding (IDLE=0, SHIFT=1) and the constant DEFAULT_WIDTH=8, shared with the existing serial-input shift logic.
REQ-027 The bit counter SHALL be a separate sub-module, bit_counter (parameter WIDTH; inputs clr and en; outputs count and last). The remaining logic stays flat.

Verification
REQ-028 Reset: rst_n low 2 cycles -> dout=0, dout_valid=0, frame_start=0, busy=0, load_ready=1.
REQ-029 Single word 8'hA5 accepted at edge k -> dout 1,0,1,0,0,1,0,1 on cycles k+1..k+8; frame_start only at k+1; dout_valid=0 from k+9.
REQ-030 Back-to-back 8'h0F then 8'hF0, load_valid held high -> 16 contiguous valid bits 1111000000001111; frame_start at bit 0 and bit 8; load_ready low while buf_full.
REQ-031 load_valid held with load_data 8'h3C for 20 cycles while ready toggles -> word accepted only on ready cycles; each transmitted 8'h3C maps to exactly one handshake.
REQ-032 8'hFF, rst_n pulled low during bit 3 with 8'h55 buffered -> next cycle dout_valid=0; 8'h55 never appears; load_ready=1.
REQ-033 WIDTH=16, word 16'h8001 -> bit 0=1, bits 1-14=0, bit 15=1; frame_start once; dout_valid low after bit 15.
